// File: rtl/bka16_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : bka16_rr_sched
// Purpose  : Round-robin scheduler that shares one registered W-bit adder
//            among NREQ requesters. It arbitrates valid/ready operand
//            requests, drives X/Y/Cin of the shared adder, tracks in-flight
//            operations through the adder latency, and returns each (W+1)-bit
//            sum tagged with the requester id through a buffered response port.
// Ports    : clk, rst (async, active-low)
//            req_valid/req_ready/req_x/req_y/req_cin : requester side
//            add_x/add_y/add_cin -> adder, add_s <- adder
//            rsp_valid/rsp_ready/rsp_id/rsp_sum      : response side
//            stat_ops/stat_stall (only with BKA_SCHED_STATS_EN defined)
// Config   : `define BKA_SCHED_STATS_EN adds the statistics counters/ports.
// Revision : 1.0  initial release
// ============================================================================
module bka16_rr_sched #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int ADD_LAT = 1,
    parameter int RSP_DEP = ADD_LAT + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_x,
    input  logic [NREQ*W-1:0]       req_y,
    input  logic [NREQ-1:0]         req_cin,
    output logic [W-1:0]            add_x,
    output logic [W-1:0]            add_y,
    output logic                    add_cin,
    input  logic [W:0]              add_s,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W:0]              rsp_sum
`ifdef BKA_SCHED_STATS_EN
    ,
    output logic [31:0]             stat_ops,
    output logic [31:0]             stat_stall
`endif
);

    localparam int c_IDW = $clog2(NREQ);
    localparam int c_PW  = $clog2(RSP_DEP);
    localparam int c_CW  = $clog2(RSP_DEP + 1);

    logic [c_IDW-1:0] r_ptr;
    logic [c_IDW-1:0] w_gnt_id;
    logic [c_IDW:0]   w_idx;
    logic             w_found;
    logic             w_gnt;
    logic             w_push;
    logic             w_pop;
    logic [c_CW-1:0]  r_credits;

    // In-flight tag pipe; stage ADD_LAT lines up with add_s for the tagged op.
    logic [ADD_LAT:0] r_pv;
    logic [c_IDW-1:0] r_pid [ADD_LAT+1];

    // Response FIFO
    logic [c_IDW-1:0] r_fid  [RSP_DEP];
    logic [W:0]       r_fsum [RSP_DEP];
    logic [c_PW-1:0]  r_wp;
    logic [c_PW-1:0]  r_rp;
    logic [c_CW-1:0]  r_cnt;

    // First asserted request at or after r_ptr, wrapping modulo NREQ.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (c_IDW+1)'(k);
            if (w_idx >= (c_IDW+1)'(NREQ)) begin
                w_idx = w_idx - (c_IDW+1)'(NREQ);
            end
            if (!w_found && req_valid[w_idx[c_IDW-1:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx[c_IDW-1:0];
            end
        end
    end

    // Qualifying with rst keeps req_ready low while reset is held, even though
    // the credit counter already holds its reset value.
    assign w_gnt = rst & w_found & (r_credits != '0);

    always_comb begin
        req_ready = '0;
        if (w_gnt) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    assign w_push    = r_pv[ADD_LAT];
    assign rsp_valid = (r_cnt != '0);
    assign rsp_id    = r_fid[r_rp];
    assign rsp_sum   = r_fsum[r_rp];
    assign w_pop     = rsp_valid & rsp_ready;

    // Issue: operands, round-robin pointer, tag pipe, credits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_x     <= '0;
            add_y     <= '0;
            add_cin   <= 1'b0;
            r_ptr     <= '0;
            r_pv      <= '0;
            r_credits <= c_CW'(RSP_DEP);
            for (int s = 0; s <= ADD_LAT; s++) begin
                r_pid[s] <= '0;
            end
        end else begin
            if (w_gnt) begin
                add_x   <= req_x[w_gnt_id*W +: W];
                add_y   <= req_y[w_gnt_id*W +: W];
                add_cin <= req_cin[w_gnt_id];
                if (w_gnt_id == c_IDW'(NREQ - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_gnt_id + 1'b1;
                end
            end
            r_pv[0]  <= w_gnt;
            r_pid[0] <= w_gnt_id;
            for (int s = 1; s <= ADD_LAT; s++) begin
                r_pv[s]  <= r_pv[s-1];
                r_pid[s] <= r_pid[s-1];
            end
            // A credit covers a slot from grant until the response is popped,
            // so the FIFO can always absorb whatever leaves the adder.
            case ({w_gnt, w_pop})
                2'b10:   r_credits <= r_credits - 1'b1;
                2'b01:   r_credits <= r_credits + 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Response FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < RSP_DEP; i++) begin
                r_fid[i]  <= '0;
                r_fsum[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fid[r_wp]  <= r_pid[ADD_LAT];
                r_fsum[r_wp] <= add_s;
                r_wp         <= (r_wp == c_PW'(RSP_DEP - 1)) ? '0 : r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= (r_rp == c_PW'(RSP_DEP - 1)) ? '0 : r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef BKA_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (w_pop) begin
                stat_ops <= stat_ops + 32'd1;
            end
            if ((|req_valid) && !w_gnt) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bka16_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bka16_rr_sched
// Purpose  : Directed self-checking bench for bka16_rr_sched with a
//            registered one-cycle adder model on the add_* side.
// Revision : 1.0  initial release
// ============================================================================
module tb_bka16_rr_sched;

    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int ADD_LAT = 1;
    localparam int RSP_DEP = ADD_LAT + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x = '0;
    logic [NREQ*W-1:0] req_y = '0;
    logic [NREQ-1:0]   req_cin = '0;
    logic [W-1:0]      add_x;
    logic [W-1:0]      add_y;
    logic              add_cin;
    logic [W:0]        add_s = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_id;
    logic [W:0]        rsp_sum;
`ifdef BKA_SCHED_STATS_EN
    logic [31:0]       stat_ops;
    logic [31:0]       stat_stall;
`endif

    bka16_rr_sched #(
        .NREQ(NREQ), .W(W), .ADD_LAT(ADD_LAT), .RSP_DEP(RSP_DEP)
    ) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin), .add_s(add_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum)
`ifdef BKA_SCHED_STATS_EN
        , .stat_ops(stat_ops), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // Registered adder, one cycle from X/Y/Cin to S.
    always_ff @(posedge clk) begin
        add_s <= {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every completed response handshake, {id, sum}, in pop order.
    logic [W+2:0] rsp_log[$];
    always @(negedge clk) begin
        #2;
        if (rst && rsp_valid && rsp_ready) begin
            rsp_log.push_back({rsp_id, rsp_sum});
        end
    end

    function automatic int oh2i(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_op(input int r, input logic [15:0] x, input logic [15:0] y, input logic c);
        req_x[r*W +: W] = x;
        req_y[r*W +: W] = y;
        req_cin[r]      = c;
    endtask

    // One isolated op: grant, operand register, latency and response.
    task automatic do_op(input int r, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic [16:0] exp_sum);
        int lat;
        @(negedge clk);
        set_op(r, x, y, c);
        req_valid    = '0;
        req_valid[r] = 1'b1;
        #1;
        chk("op_ready", 32'(req_ready), 32'(1) << r);
        @(negedge clk);
        req_valid = '0;
        chk("op_add_x", 32'(add_x), 32'(x));
        chk("op_add_y", 32'(add_y), 32'(y));
        chk("op_add_cin", 32'(add_cin), 32'(c));
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("op_latency", 32'(lat), 32'(ADD_LAT + 2));
        chk("op_rsp_id", 32'(rsp_id), 32'(r));
        chk("op_rsp_sum", 32'(rsp_sum), 32'(exp_sum));
    endtask

    // Hand-computed operand sets; sum = x + y + cin in 17 bits.
    logic [15:0] rr_x [4] = '{16'h1000, 16'h8000, 16'h7FFF, 16'hFFFF};
    logic [15:0] rr_y [4] = '{16'h0234, 16'h8000, 16'h0000, 16'hFFFF};
    logic        rr_c [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [16:0] rr_s [4] = '{17'h01234, 17'h10001, 17'h08000, 17'h1FFFF};

    logic [15:0] bp_x [4] = '{16'h0001, 16'h00FF, 16'hF0F0, 16'hC000};
    logic [15:0] bp_y [4] = '{16'h0002, 16'h0001, 16'h0F0F, 16'h4000};
    logic        bp_c [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [16:0] bp_s [4] = '{17'h00003, 17'h00100, 17'h0FFFF, 17'h10000};

    int gq[$];
    int cyc;
    int over;
    int stale;
    logic [W+2:0] e;

    initial begin
        // ---------------- reset state ----------------
        req_valid = '1;
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_add_x", 32'(add_x), 32'h0);
        chk("rst_add_y", 32'(add_y), 32'h0);
        chk("rst_add_cin", 32'(add_cin), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'h0);
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- single ops ----------------
        do_op(0, 16'h000A, 16'h0005, 1'b0, 17'h0000F);
        do_op(1, 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
        do_op(2, 16'hAAAA, 16'h5555, 1'b1, 17'h10000);
        do_op(3, 16'h1234, 16'h4321, 1'b1, 17'h05556);

        // ---------------- round robin ----------------
        for (int i = 0; i < NREQ; i++) set_op(i, rr_x[i], rr_y[i], rr_c[i]);
        @(negedge clk);
        rsp_log.delete();
        gq.delete();
        req_valid = '1;
        cyc = 0;
        while (gq.size() < 8 && cyc < 40) begin
            #1;
            if (req_ready != '0) gq.push_back(oh2i(req_ready));
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        chk("rr_grants", 32'(gq.size()), 32'd8);
        for (int k = 0; k < gq.size(); k++) chk("rr_grant_order", 32'(gq[k]), 32'(k % 4));
        cyc = 0;
        while (rsp_log.size() < 8 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        #3;
        chk("rr_rsp_count", 32'(rsp_log.size()), 32'd8);
        for (int k = 0; k < rsp_log.size(); k++) begin
            e = rsp_log[k];
            chk("rr_rsp_id", 32'(e[W+2:W+1]), 32'(k % 4));
            chk("rr_rsp_sum", 32'(e[W:0]), 32'(rr_s[k % 4]));
        end

        // ---------------- backpressure ----------------
        for (int i = 0; i < NREQ; i++) set_op(i, bp_x[i], bp_y[i], bp_c[i]);
        @(negedge clk);
        rsp_ready = 1'b0;
        rsp_log.delete();
        gq.delete();
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready != '0) gq.push_back(oh2i(req_ready));
            @(negedge clk);
        end
        #1;
        chk("bp_accepted", 32'(gq.size()), 32'(RSP_DEP));
        chk("bp_ready_zero", 32'(req_ready), 32'h0);
        chk("bp_head_valid", 32'(rsp_valid), 32'h1);
        chk("bp_head_id", 32'(rsp_id), 32'h0);
        chk("bp_head_sum", 32'(rsp_sum), 32'(bp_s[0]));
        @(negedge clk);
        #1;
        chk("bp_head_stable", 32'(rsp_sum), 32'(bp_s[0]));
        @(negedge clk);
        rsp_ready = 1'b1;
        over = 0;
        cyc  = 0;
        while (gq.size() < 9 && cyc < 60) begin
            #1;
            if (req_ready != '0) gq.push_back(oh2i(req_ready));
            if (gq.size() - rsp_log.size() > RSP_DEP) over = 1;
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        cyc = 0;
        while (rsp_log.size() < 9 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        #3;
        chk("bp_no_overrun", 32'(over), 32'h0);
        chk("bp_grants", 32'(gq.size()), 32'd9);
        chk("bp_rsp_count", 32'(rsp_log.size()), 32'd9);
        for (int k = 0; k < rsp_log.size(); k++) begin
            e = rsp_log[k];
            chk("bp_rsp_id", 32'(e[W+2:W+1]), 32'(k % 4));
            chk("bp_rsp_sum", 32'(e[W:0]), 32'(bp_s[k % 4]));
        end

        // ---------------- reset mid-stream ----------------
        @(negedge clk);
        rsp_ready = 1'b0;
        gq.delete();
        req_valid = '1;
        cyc = 0;
        while (gq.size() < 3 && cyc < 20) begin
            #1;
            if (req_ready != '0) gq.push_back(oh2i(req_ready));
            @(negedge clk);
            cyc++;
        end
        chk("mr_inflight", 32'(gq.size()), 32'd3);
        #1;
        rst = 1'b0;
        #2;
        chk("mr_req_ready", 32'(req_ready), 32'h0);
        chk("mr_add_x", 32'(add_x), 32'h0);
        chk("mr_add_y", 32'(add_y), 32'h0);
        chk("mr_add_cin", 32'(add_cin), 32'h0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mr_rsp_id", 32'(rsp_id), 32'h0);
        chk("mr_rsp_sum", 32'(rsp_sum), 32'h0);
        req_valid = '0;
        @(negedge clk);
        rst       = 1'b1;
        rsp_ready = 1'b1;
        rsp_log.delete();
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (rsp_valid) stale = 1;
            @(negedge clk);
        end
        chk("mr_no_stale", 32'(stale), 32'h0);
        chk("mr_no_stale_log", 32'(rsp_log.size()), 32'h0);
        req_valid = '1;
        #1;
        chk("mr_ptr_reset", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
